// File: rtl/aircon_scheduler.sv
// Heater/cooler sequencing FSM with hysteresis, minimum run time and a dead time between runs.
// One shared cycle counter times both the run minimum and the dead time.
module aircon_scheduler #(
    parameter int HEAT_ON   = 18,
    parameter int TARGET    = 20,
    parameter int COOL_ON   = 22,
    parameter int MIN_RUN   = 4,
    parameter int DEAD_TIME = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [4:0] temperature,
    output logic       heating,
    output logic       cooling,
    output logic       lockout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HEAT = 2'b01,
        S_COOL = 2'b10,
        S_LOCK = 2'b11
    } state_t;

    localparam logic [4:0]       HEAT_ON_T = 5'(HEAT_ON);
    localparam logic [4:0]       TARGET_T  = 5'(TARGET);
    localparam logic [4:0]       COOL_ON_T = 5'(COOL_ON);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MIN_RUN - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             heating_q, cooling_q, lockout_q;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable && temperature <= HEAT_ON_T) begin
                    state_d = S_HEAT;
                end else if (enable && temperature >= COOL_ON_T) begin
                    state_d = S_COOL;
                end
            end
            S_HEAT: begin
                // enable low cuts the run short; otherwise hold until target and minimum run are both met
                if (!enable || (temperature >= TARGET_T && cnt_q >= RUN_LAST)) begin
                    state_d = S_LOCK;
                    cnt_d   = '0;
                end
            end
            S_COOL: begin
                if (!enable || (temperature <= TARGET_T && cnt_q >= RUN_LAST)) begin
                    state_d = S_LOCK;
                    cnt_d   = '0;
                end
            end
            S_LOCK: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            heating_q <= 1'b0;
            cooling_q <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            heating_q <= (state_d == S_HEAT);
            cooling_q <= (state_d == S_COOL);
            lockout_q <= (state_d == S_LOCK);
        end
    end

    assign heating = heating_q;
    assign cooling = cooling_q;
    assign lockout = lockout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_aircon_scheduler.sv
// Bench for aircon_scheduler: directed vectors into a scoreboard queue, plus a randomised
// phase with run-length, dead-time and mutual-exclusion checks.
module tb_aircon_scheduler;

    localparam logic [1:0] I = 2'b00, H = 2'b01, C = 2'b10, L = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [4:0] temperature = 5'd20;
    logic       heating, cooling, lockout;
    logic [1:0] state;

    always #5 clk = ~clk;

    aircon_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .temperature(temperature),
        .heating    (heating),
        .cooling    (cooling),
        .lockout    (lockout),
        .state      (state)
    );

    typedef struct {
        logic [1:0] st;
        int         idx;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_step = 0;
    bit         rand_on = 1'b0;

    // Drive one cycle of inputs and queue the state expected after the following edge.
    task automatic step(input logic r, input logic en, input logic [4:0] t, input logic [1:0] e);
        exp_t x;
        @(negedge clk);
        rst = r;
        enable = en;
        temperature = t;
        x.st = e;
        x.idx = n_step;
        sb.push_back(x);
        n_step++;
    endtask

    task automatic rep(input int n, input logic r, input logic en, input logic [4:0] t,
                       input logic [1:0] e);
        for (int i = 0; i < n; i++) step(r, en, t, e);
    endtask

    // Scoreboard monitor
    exp_t       mx;
    logic [4:0] mgot, mwant;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mx = sb.pop_front();
            mgot  = {state, heating, cooling, lockout};
            mwant = {mx.st, mx.st == H, mx.st == C, mx.st == L};
            n_cmp++;
            if (mgot !== mwant) begin
                n_err++;
                $display("FAIL vec%0d {state,heat,cool,lock}: got %b required %b", mx.idx, mgot, mwant);
            end
        end
    end

    // Invariant checker for the random phase
    logic [1:0] pstate = I;
    int         run_len = 0;
    int         lock_len = 0;
    always @(posedge clk) begin
        #1;
        if (rand_on) begin
            n_cmp++;
            if (heating && cooling) begin
                n_err++;
                $display("FAIL excl: heating=%b cooling=%b required not both 1", heating, cooling);
            end
            if (state == H || state == C) run_len = (pstate == state) ? run_len + 1 : 1;
            if (state == L) lock_len = (pstate == L) ? lock_len + 1 : 1;
            if ((pstate == H || pstate == C) && state != pstate) begin
                n_cmp++;
                if (state != L || (enable && run_len < 4)) begin
                    n_err++;
                    $display("FAIL run_end: next state %b len %0d enable %b required LOCK and len>=4 unless enable=0",
                             state, run_len, enable);
                end
            end
            if (pstate == L && state != L) begin
                n_cmp++;
                if (lock_len != 3 || state != I) begin
                    n_err++;
                    $display("FAIL dead_time: lock len %0d then state %b required 3 then 00", lock_len, state);
                end
            end
            pstate = state;
        end
    end

    initial begin
        int cyc;
        int hold;
        // reset, then non-triggering temperatures
        rep(2, 1'b1, 1'b1, 5'd20, I);
        rep(20, 1'b0, 1'b1, 5'd20, I);
        rep(20, 1'b0, 1'b1, 5'd19, I);
        rep(20, 1'b0, 1'b1, 5'd21, I);

        // heat at threshold, minimum run, dead time, one idle cycle, then cool
        step(1'b0, 1'b1, 5'd18, H);
        rep(3, 1'b0, 1'b1, 5'd25, H);
        rep(3, 1'b0, 1'b1, 5'd25, L);
        step(1'b0, 1'b1, 5'd25, I);
        step(1'b0, 1'b1, 5'd25, C);
        // cool exits at exactly TARGET once minimum run is met
        rep(3, 1'b0, 1'b1, 5'd20, C);
        rep(3, 1'b0, 1'b1, 5'd20, L);
        step(1'b0, 1'b1, 5'd20, I);

        // cool at threshold, long run, exit at target
        rep(10, 1'b0, 1'b1, 5'd22, C);
        rep(3, 1'b0, 1'b1, 5'd20, L);
        step(1'b0, 1'b1, 5'd20, I);

        // heating run cut short by enable, then disabled idle with cold room
        rep(2, 1'b0, 1'b1, 5'd18, H);
        step(1'b0, 1'b0, 5'd18, L);
        rep(2, 1'b0, 1'b0, 5'd10, L);
        rep(5, 1'b0, 1'b0, 5'd10, I);

        // reset mid cooling run
        rep(2, 1'b0, 1'b1, 5'd25, C);
        step(1'b1, 1'b1, 5'd25, I);
        step(1'b0, 1'b0, 5'd20, I);

        // random phase
        @(negedge clk);
        rand_on = 1'b1;
        cyc = 0;
        while (cyc < 2000) begin
            hold = int'($urandom_range(1, 10));
            temperature = 5'($urandom_range(10, 30));
            enable = ($urandom_range(0, 3) != 0);
            repeat (hold) @(negedge clk);
            cyc += hold;
        end
        rand_on = 1'b0;

        rep(2, 1'b1, 1'b0, 5'd20, I);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
